bp_update_ctrl: RTL

Update sequencer for the branch-predictor cache (`bp_cache`, 2-bit counters by default). It accepts branch-resolution events from the execute stage, buffers them in a small FIFO and performs a pipelined read-modify-write of the saturating counter. It uses the cache's second read port and its single write port, and forwards in-flight writes to avoid RAW hazards. It sits between the execute stage and `bp_cache`; fetch keeps exclusive use of read port 0.

---
 rtl/bp_update_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: update sequencer for the branch-predictor cache.
// Buffers branch-resolution events in a small FIFO and performs a pipelined
// read-modify-write of the saturating counter through the cache's second read
// port and its write port, forwarding the in-flight write to avoid RAW hazards.
// Ports:
//   clk, reset (async, active-low)
//   upd_valid/upd_ready/upd_pc/upd_taken/upd_pred : resolution event input
//   flush                                          : discard queued events
//   bp_ra/bp_dout/bp_hit                           : cache read port 1
//   bp_wa/bp_din/bp_we                             : cache write port
//   busy, n_updates, n_mispredicts                 : status and statistics
module bp_update_ctrl #(
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned DWIDTH    = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [AWIDTH-1:0]    upd_pc,
  input  logic                 upd_taken,
  input  logic                 upd_pred,
  input  logic                 flush,
  output logic [AWIDTH-1:0]    bp_ra,
  input  logic [DWIDTH-1:0]    bp_dout,
  input  logic                 bp_hit,
  output logic [AWIDTH-1:0]    bp_wa,
  output logic [DWIDTH-1:0]    bp_din,
  output logic                 bp_we,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] n_updates,
  output logic [CNT_WIDTH-1:0] n_mispredicts
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [DWIDTH-1:0] CNT_MAX = {DWIDTH{1'b1}};
  localparam logic [DWIDTH-1:0] WEAK_T  = DWIDTH'(1) << (DWIDTH - 1);
  localparam logic [DWIDTH-1:0] WEAK_NT = ~WEAK_T;

  logic [AWIDTH-1:0] fifo_pc [DEPTH];
  logic [DEPTH-1:0]  fifo_taken;
  logic [DEPTH-1:0]  fifo_mis;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [AWIDTH-1:0] head_pc;
  logic              head_taken;
  logic              head_mis;
  logic              fwd;
  logic              known;
  logic [DWIDTH-1:0] cur;
  logic [DWIDTH-1:0] nxt;

  // Occupancy, handshake and head-of-queue view
  always_comb begin
    full       = (count == CW'(DEPTH));
    empty      = (count == '0);
    upd_ready  = !full && !flush && reset;
    push       = upd_valid && upd_ready;
    pop        = !empty && !flush;
    head_pc    = fifo_pc[rd_ptr];
    head_taken = fifo_taken[rd_ptr];
    head_mis   = fifo_mis[rd_ptr];
    bp_ra      = empty ? '0 : head_pc;
    busy       = !empty || bp_we;
  end

  // S1: pick current counter (forwarded write wins over cache) and update it
  always_comb begin
    fwd   = bp_we && (bp_wa == head_pc);
    cur   = fwd ? bp_din : bp_dout;
    known = fwd || bp_hit;
    nxt   = cur;
    if (known) begin
      if (head_taken) begin
        nxt = (cur == CNT_MAX) ? cur : cur + DWIDTH'(1);
      end else begin
        nxt = (cur == '0) ? cur : cur - DWIDTH'(1);
      end
    end else begin
      nxt = head_taken ? WEAK_T : WEAK_NT;
    end
  end

  // FIFO payload storage; contents are only meaningful below count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= upd_pc;
      fifo_taken[wr_ptr] <= upd_taken;
      fifo_mis[wr_ptr]   <= (upd_pred != upd_taken);
    end
  end

  // Pointers, write-port registers and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      bp_we         <= 1'b0;
      bp_wa         <= '0;
      bp_din        <= '0;
      n_updates     <= '0;
      n_mispredicts <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
      bp_we <= pop;
      if (pop) begin
        bp_wa     <= head_pc;
        bp_din    <= nxt;
        n_updates <= n_updates + CNT_WIDTH'(1);
        if (head_mis) n_mispredicts <= n_mispredicts + CNT_WIDTH'(1);
      end
    end
  end

endmodule
